fetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the IF/ID pipeline register and the decode stage.
- Owns the PC register and issues requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a small FIFO so decode can stall.
- Accepts a single redirect (branch/jump) from later stages, which flushes everything in flight and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous fetch queue (DEPTH must be a power of two, 2 or 4).
// Clear wins over push; push into a full queue is only accepted together with a pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t push_data,
   output fetch_entry_t head,
   output logic [2:0]   count
);

   localparam int          PW      = $clog2(DEPTH);
   localparam logic [2:0]  DEPTH_C = 3'(DEPTH);

   fetch_entry_t  mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [2:0]    count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Qualify push/pop against current occupancy.
   always_comb begin
      do_pop_s  = pop && (count_r != 3'd0);
      do_push_s = push && ((count_r < DEPTH_C) || do_pop_s);
   end

   // Pointer, occupancy and storage update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= 3'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= 3'd0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, 1-cycle imem requests, fetch queue, redirect flush.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          FQ_DEPTH  = 2,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [2:0]  fq_count
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   fetch_state_t state_r;
   logic [31:0]  pc_r;
   logic         inflight_r;
   logic [31:0]  tag_r;
   logic [31:0]  last_pc_r;
   logic [31:0]  last_pc4_r;

   fetch_entry_t head_s;
   fetch_entry_t entry_s;
   logic [2:0]   count_s;
   logic [3:0]   occ_s;
   logic         valid_s;
   logic         pop_s;
   logic         issue_s;
   logic         push_s;
   logic         drop_s;

   // Handshake, issue and response-accept decisions.
   always_comb begin
      valid_s = (count_s != 3'd0);
      pop_s   = valid_s && id_ready && !redirect_valid;
      occ_s   = 4'(count_s) + 4'(inflight_r) - 4'(pop_s);
      if ((state_r == BOOT) || redirect_valid) begin
         issue_s = 1'b0;
      end else begin
         issue_s = (occ_s < 4'(FQ_DEPTH));
      end
      push_s        = inflight_r && (state_r != FLUSH) && !redirect_valid;
      drop_s        = inflight_r && !push_s;
      entry_s.pc    = tag_r;
      entry_s.instr = imem_rdata;
   end

   fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .pop       (pop_s),
      .clear     (redirect_valid),
      .push_data (entry_s),
      .head      (head_s),
      .count     (count_s)
   );

   // Fetch FSM: PC, in-flight flag and response tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= BOOT;
         pc_r       <= RESET_PC;
         inflight_r <= 1'b0;
         tag_r      <= 32'd0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            tag_r <= pc_r;
         end
         case (state_r)
            BOOT: begin
               state_r <= RUN;
               if (redirect_valid) begin
                  pc_r <= word_align(redirect_pc);
               end
            end
            RUN, FLUSH: begin
               if (redirect_valid) begin
                  pc_r    <= word_align(redirect_pc);
                  state_r <= inflight_r ? FLUSH : RUN;
               end else begin
                  state_r <= RUN;
                  if (issue_s) begin
                     pc_r <= pc_r + 32'd4;
                  end
               end
            end
            default: state_r <= BOOT;
         endcase
      end
   end

   // Remember the last presented head so id_pc holds while the queue is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_pc_r  <= 32'd0;
         last_pc4_r <= 32'd0;
      end else if (valid_s) begin
         last_pc_r  <= head_s.pc;
         last_pc4_r <= head_s.pc + 32'd4;
      end
   end

   assign imem_req    = issue_s;
   assign imem_addr   = pc_r;
   assign id_valid    = valid_s;
   assign id_instr    = valid_s ? head_s.instr : NOP_INSTR;
   assign id_pc       = valid_s ? head_s.pc : last_pc_r;
   assign id_pc_plus4 = valid_s ? (head_s.pc + 32'd4) : last_pc4_r;
   assign fq_count    = count_s;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_r;
   logic [31:0] perf_flushed_r;

   // Pushes, plus entries cleared and responses dropped because of redirects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_r <= 32'd0;
         perf_flushed_r <= 32'd0;
      end else begin
         perf_fetched_r <= perf_fetched_r + 32'(push_s);
         if (redirect_valid) begin
            perf_flushed_r <= perf_flushed_r + 32'(count_s) + 32'(drop_s);
         end else begin
            perf_flushed_r <= perf_flushed_r + 32'(drop_s);
         end
      end
   end

   assign perf_fetched = perf_fetched_r;
   assign perf_flushed = perf_flushed_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed test-plan scenarios, then randomized traffic.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        id_ready = 1'b1;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [2:0]  fq_count;

   int n_checks = 0;
   int n_fail   = 0;
   int pops     = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t            exp_q[$];
   longint unsigned next_pc;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC  (RST_PC),
      .FQ_DEPTH  (DEPTH),
      .NOP_INSTR (NOP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4),
      .fq_count       (fq_count)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous instruction memory with one-cycle read latency.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected decode stream: consecutive words from the last restart point, wrapping at 2^32.
   function automatic void sb_fill();
      while (exp_q.size() < 16) begin
         exp_t e;
         e.pc    = next_pc[31:0];
         e.instr = mem_word(e.pc);
         next_pc = (next_pc + 64'd4) % 64'h1_0000_0000;
         e.pc4   = next_pc[31:0];
         exp_q.push_back(e);
      end
   endfunction

   function automatic void sb_restart(input logic [31:0] start);
      exp_q.delete();
      next_pc = (64'(start) / 64'd4) * 64'd4;
      sb_fill();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      sb_fill();
   endtask

   // Monitor: every accepted decode handshake must match the next expected entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         check("fq_count_bound", 32'(fq_count <= 3'(DEPTH)), 32'd1);
         if (!id_valid) check("nop_when_idle", id_instr, NOP);
         if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
         if (id_valid && id_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got pc %h expected no pop", id_pc);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", id_pc, e.pc);
               check("pop_instr", id_instr, e.instr);
               check("pop_pc_plus4", id_pc_plus4, e.pc4);
               pops++;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : drive
      logic [31:0] stall_pc;
      int          pops_before;
      sb_restart(RST_PC);
      repeat (3) tick();
      @(negedge clk);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_instr", id_instr, NOP);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_id_pc_plus4", id_pc_plus4, 32'd0);
      check("rst_fq_count", 32'(fq_count), 32'd0);

      // cycle 0 (BOOT) .. cycle 3
      tick(); rst_n = 1'b1;
      @(negedge clk); check("boot_no_req", 32'(imem_req), 32'd0);
      tick(); @(negedge clk);
      check("c1_req", 32'(imem_req), 32'd1);
      check("c1_addr", imem_addr, 32'h0000_0100);
      tick(); @(negedge clk);
      check("c2_addr", imem_addr, 32'h0000_0104);
      check("c2_id_valid", 32'(id_valid), 32'd0);
      tick(); @(negedge clk);
      check("c3_addr", imem_addr, 32'h0000_0108);
      check("c3_id_valid", 32'(id_valid), 32'd1);
      check("c3_id_pc", id_pc, 32'h0000_0100);
      tick();

      // stall for six cycles from cycle 5
      tick(); id_ready = 1'b0;
      @(negedge clk); stall_pc = id_pc;
      repeat (5) tick();
      @(negedge clk);
      check("stall_fq_count", 32'(fq_count), 32'd2);
      check("stall_req_low", 32'(imem_req), 32'd0);
      check("stall_pc_frozen", id_pc, stall_pc);
      tick(); id_ready = 1'b1;
      repeat (4) tick();

      // redirect with a request in flight
      @(negedge clk); check("pre_redirect_req", 32'(imem_req), 32'd1);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_2003; sb_restart(redirect_pc);
      @(negedge clk); check("redirect_req_low", 32'(imem_req), 32'd0);
      tick(); redirect_valid = 1'b0;
      @(negedge clk);
      check("r1_req", 32'(imem_req), 32'd1);
      check("r1_addr", imem_addr, 32'h0000_2000);
      check("r1_id_valid", 32'(id_valid), 32'd0);
      tick(); @(negedge clk); check("r2_id_valid", 32'(id_valid), 32'd0);
      tick(); @(negedge clk);
      check("r3_id_valid", 32'(id_valid), 32'd1);
      check("r3_id_pc", id_pc, 32'h0000_2000);

      // PC wrap
      repeat (3) tick();
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; sb_restart(redirect_pc);
      tick(); redirect_valid = 1'b0;
      @(negedge clk); check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      tick(); @(negedge clk); check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
      tick(); @(negedge clk); check("wrap_addr2", imem_addr, 32'h0000_0000);
      tick(); @(negedge clk);
      check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
      check("wrap_id_pc_plus4", id_pc_plus4, 32'h0000_0000);

      // back-to-back redirects
      repeat (3) tick();
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; sb_restart(redirect_pc);
      tick(); redirect_pc = 32'h0000_0800; sb_restart(redirect_pc);
      @(negedge clk); check("b2b_req_low", 32'(imem_req), 32'd0);
      tick(); redirect_valid = 1'b0;
      @(negedge clk); check("b2b_addr", imem_addr, 32'h0000_0800);
      tick(); tick(); @(negedge clk);
      check("b2b_id_valid", 32'(id_valid), 32'd1);
      check("b2b_id_pc", id_pc, 32'h0000_0800);

      // asynchronous reset with a full queue
      repeat (3) tick();
      tick(); id_ready = 1'b0;
      repeat (4) tick();
      @(negedge clk); check("full_before_reset", 32'(fq_count), 32'd2);
      tick(); rst_n = 1'b0; sb_restart(RST_PC);
      #1;
      check("async_rst_id_valid", 32'(id_valid), 32'd0);
      check("async_rst_fq_count", 32'(fq_count), 32'd0);
      tick(); id_ready = 1'b1;
      tick(); rst_n = 1'b1;
      tick(); @(negedge clk);
      check("restart_req", 32'(imem_req), 32'd1);
      check("restart_addr", imem_addr, RST_PC);

      // randomized traffic
      pops_before = pops;
      for (int c = 0; c < 3000; c++) begin
         tick();
         id_ready = ($urandom_range(99) < 70);
         if (!rst_n) begin
            rst_n = 1'b1;
            redirect_valid = 1'b0;
         end else if ($urandom_range(999) < 3) begin
            rst_n = 1'b0;
            redirect_valid = 1'b0;
            sb_restart(RST_PC);
         end else if ($urandom_range(99) < 5) begin
            redirect_valid = 1'b1;
            redirect_pc = $urandom();
            sb_restart(redirect_pc);
         end else begin
            redirect_valid = 1'b0;
         end
      end
      tick();
      rst_n = 1'b1;
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      repeat (10) tick();
      check("random_progress", 32'((pops - pops_before) > 1000), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
